// File: rtl/arb_pkg.sv
// Shared constants and FSM state type for the round-robin arbiter.
// Defaults describe an 8-requester arbiter with a 16-cycle hold limit.
package arb_pkg;
   localparam int ARB_N        = 8;
   localparam int ARB_IDXW     = 3;
   localparam int ARB_MAX_HOLD = 16;

   typedef enum logic {IDLE, GRANT} arb_state_t;
endpackage

// File: rtl/one_hot_encoder.sv
// One-hot to binary encoder fed by the arbiter grant vector.
// Combinational; an all-zero input encodes to 0.
module one_hot_encoder
   import arb_pkg::*;
#(
   parameter int N    = ARB_N,
   parameter int IDXW = ARB_IDXW
) (
   input  logic [N-1:0]    one_hot,
   output logic [IDXW-1:0] bin_out
);
   always_comb begin
      bin_out = '0;
      for (int i = 0; i < N; i++) begin
         if (one_hot[i]) begin
            bin_out = bin_out | IDXW'(i);
         end
      end
   end
endmodule

// File: rtl/rr_priority_pick.sv
// Wrap-around priority search: first set bit of req at or above ptr, else lowest set bit.
// Purely combinational; pick is all-zero when req is all-zero.
module rr_priority_pick
   import arb_pkg::*;
#(
   parameter int N    = ARB_N,
   parameter int IDXW = ARB_IDXW
) (
   input  logic [N-1:0]    req,
   input  logic [IDXW-1:0] ptr,
   output logic [N-1:0]    pick,
   output logic [IDXW-1:0] pick_idx
);
   logic [N-1:0]    upper;
   logic [IDXW-1:0] upper_idx;
   logic [IDXW-1:0] low_idx;

   always_comb begin
      upper = '0;
      for (int i = 0; i < N; i++) begin
         upper[i] = req[i] && (IDXW'(i) >= ptr);
      end
   end

   // Descending scans leave the lowest set position in the index.
   always_comb begin
      upper_idx = '0;
      low_idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (upper[i]) begin
            upper_idx = IDXW'(i);
         end
         if (req[i]) begin
            low_idx = IDXW'(i);
         end
      end
   end

   always_comb begin
      pick     = '0;
      pick_idx = '0;
      if (|upper) begin
         pick_idx = upper_idx;
         pick[upper_idx] = 1'b1;
      end else if (|req) begin
         pick_idx = low_idx;
         pick[low_idx] = 1'b1;
      end
   end
endmodule

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with ack/withdraw/timeout release and zero-bubble handover.
// Grant appears one cycle after request; all outputs are registered.
module round_robin_arbiter
   import arb_pkg::*;
#(
   parameter int N        = ARB_N,
   parameter int IDXW     = ARB_IDXW,
   parameter int MAX_HOLD = ARB_MAX_HOLD
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic            ack,
   output logic [N-1:0]    gnt,
   output logic            gnt_valid,
   output logic [IDXW-1:0] gnt_idx,
   output logic            timeout
);
   localparam int CNTW = $clog2(MAX_HOLD + 1);

   arb_state_t      state;
   logic [IDXW-1:0] ptr;
   logic [CNTW-1:0] hold_cnt;

   logic            hold_hit;
   logic            rel;
   logic [IDXW-1:0] ptr_next;
   logic [IDXW-1:0] pick_ptr;
   logic [N-1:0]    pick_req;
   logic [N-1:0]    pick;
   logic [IDXW-1:0] pick_idx;

   assign hold_hit = (hold_cnt == CNTW'(MAX_HOLD - 1));
   assign rel      = ack || !req[gnt_idx] || hold_hit;
   assign ptr_next = (gnt_idx == IDXW'(N - 1)) ? '0 : gnt_idx + IDXW'(1);

   // During a release the holder is excluded, so handover only goes to someone else.
   assign pick_ptr = (state == GRANT) ? ptr_next : ptr;
   assign pick_req = (state == GRANT) ? (req & ~gnt) : req;

   rr_priority_pick #(
      .N    (N),
      .IDXW (IDXW)
   ) u_pick (
      .req      (pick_req),
      .ptr      (pick_ptr),
      .pick     (pick),
      .pick_idx (pick_idx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         gnt       <= '0;
         gnt_valid <= 1'b0;
         gnt_idx   <= '0;
         timeout   <= 1'b0;
         ptr       <= '0;
         hold_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               timeout  <= 1'b0;
               hold_cnt <= '0;
               if (|req) begin
                  state     <= GRANT;
                  gnt       <= pick;
                  gnt_idx   <= pick_idx;
                  gnt_valid <= 1'b1;
               end
            end
            GRANT: begin
               if (rel) begin
                  ptr      <= ptr_next;
                  timeout  <= hold_hit && !ack;
                  hold_cnt <= '0;
                  if (|pick_req) begin
                     gnt     <= pick;
                     gnt_idx <= pick_idx;
                  end else begin
                     state     <= IDLE;
                     gnt       <= '0;
                     gnt_valid <= 1'b0;
                     gnt_idx   <= '0;
                  end
               end else begin
                  timeout  <= 1'b0;
                  hold_cnt <= hold_cnt + CNTW'(1);
               end
            end
            default: begin
               state     <= IDLE;
               gnt       <= '0;
               gnt_valid <= 1'b0;
               gnt_idx   <= '0;
               timeout   <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_round_robin_arbiter.sv
// Bench for round_robin_arbiter: directed scenarios plus random req/ack against a behavioural model.
module tb_round_robin_arbiter;
   localparam int N        = 8;
   localparam int IDXW     = 3;
   localparam int MAX_HOLD = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req;
   logic            ack;
   logic [N-1:0]    gnt;
   logic            gnt_valid;
   logic [IDXW-1:0] gnt_idx;
   logic            timeout;
   logic [IDXW-1:0] bin_out;

   always #5 clk = ~clk;

   round_robin_arbiter #(
      .N        (N),
      .IDXW     (IDXW),
      .MAX_HOLD (MAX_HOLD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .ack       (ack),
      .gnt       (gnt),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx),
      .timeout   (timeout)
   );

   one_hot_encoder #(
      .N    (N),
      .IDXW (IDXW)
   ) enc (
      .one_hot (gnt),
      .bin_out (bin_out)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Model: who holds the grant, for how many visible cycles, and where the next search starts.
   bit m_busy;
   int m_holder;
   int m_ptr;
   int m_held;
   bit m_to;

   function automatic int first_from(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++) begin
         if (v[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_holder = 0; m_ptr = 0; m_held = 0; m_to = 0;
   endtask

   task automatic model_step(input logic [N-1:0] r, input logic a);
      logic [N-1:0] others;
      if (!m_busy) begin
         m_to = 0;
         if (r != '0) begin
            m_holder = first_from(r, m_ptr);
            m_busy   = 1;
            m_held   = 1;
         end
      end else if (a || !r[m_holder] || m_held == MAX_HOLD) begin
         m_to   = (m_held == MAX_HOLD) && !a;
         m_ptr  = (m_holder + 1) % N;
         others = r;
         others[m_holder] = 1'b0;
         if (others != '0) begin
            m_holder = first_from(others, m_ptr);
            m_held   = 1;
         end else begin
            m_busy = 0;
         end
      end else begin
         m_held++;
         m_to = 0;
      end
   endtask

   task automatic check_model();
      logic [N-1:0] eg;
      int ei;
      eg = '0;
      ei = 0;
      if (m_busy) begin
         eg[m_holder] = 1'b1;
         ei = m_holder;
      end
      check("gnt", 32'(gnt), 32'(eg));
      check("gnt_valid", 32'(gnt_valid), 32'(m_busy));
      check("gnt_idx", 32'(gnt_idx), ei);
      check("timeout", 32'(timeout), 32'(m_to));
      check("enc_bin", 32'(bin_out), ei);
      check("onehot0", 32'($onehot0(gnt)), 32'd1);
   endtask

   task automatic cycle(input logic [N-1:0] r, input logic a);
      req = r;
      ack = a;
      @(posedge clk);
      model_step(r, a);
      #1;
      check_model();
   endtask

   initial begin
      logic [N-1:0] rr;
      logic         aa;
      rst = 1'b1;
      req = '0;
      ack = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_valid", 32'(gnt_valid), 32'd0);
      check("rst_idx", 32'(gnt_idx), 32'd0);
      check("rst_timeout", 32'(timeout), 32'd0);
      rst = 1'b0;
      cycle('0, 1'b0);

      // Asynchronous reset mid-grant, then search restarts at requester 0.
      cycle(8'h04, 1'b0);
      check("s_rst_pre", 32'(gnt), 32'h04);
      rst = 1'b1;
      #1;
      check("s_rst_async_gnt", 32'(gnt), 32'd0);
      check("s_rst_async_valid", 32'(gnt_valid), 32'd0);
      model_reset();
      #1;
      rst = 1'b0;
      cycle(8'hFF, 1'b0);
      check("s_rst_first", 32'(gnt), 32'h01);

      // Rotation with ack every cycle: no idle between grants.
      for (int k = 0; k < 9; k++) begin
         cycle(8'hFF, 1'b1);
         check("rot_idx", 32'(gnt_idx), (k + 1) % N);
         check("rot_valid", 32'(gnt_valid), 32'd1);
      end
      cycle('0, 1'b1);
      cycle('0, 1'b0);

      // Wrap from requester 7 to 0.
      cycle(8'h40, 1'b0);
      check("wrap_g6", 32'(gnt), 32'h40);
      cycle(8'h81, 1'b1);
      check("wrap_g7", 32'(gnt), 32'h80);
      cycle(8'h81, 1'b1);
      check("wrap_g0", 32'(gnt), 32'h01);
      cycle('0, 1'b1);
      cycle('0, 1'b0);

      // Timeout after MAX_HOLD cycles, then regrant; ack at the limit suppresses timeout.
      cycle(8'h08, 1'b0);
      check("to_first", 32'(gnt), 32'h08);
      for (int k = 0; k < MAX_HOLD - 1; k++) begin
         cycle(8'h08, 1'b0);
         check("to_hold", 32'(gnt), 32'h08);
         check("to_hold_pulse", 32'(timeout), 32'd0);
      end
      cycle(8'h08, 1'b0);
      check("to_pulse", 32'(timeout), 32'd1);
      check("to_idle", 32'(gnt), 32'd0);
      cycle(8'h08, 1'b0);
      check("to_regrant", 32'(gnt), 32'h08);
      check("to_pulse_once", 32'(timeout), 32'd0);
      for (int k = 0; k < MAX_HOLD - 1; k++) cycle(8'h08, 1'b0);
      cycle(8'h08, 1'b1);
      check("to_ack_prio", 32'(timeout), 32'd0);
      cycle('0, 1'b0);

      // Ack while idle is ignored.
      cycle('0, 1'b1);
      check("idle_ack", 32'(gnt_valid), 32'd0);

      // Withdrawal handover.
      cycle(8'h04, 1'b0);
      check("wd_g2", 32'(gnt), 32'h04);
      cycle(8'h10, 1'b0);
      check("wd_g4", 32'(gnt), 32'h10);
      check("wd_timeout", 32'(timeout), 32'd0);
      cycle('0, 1'b1);
      cycle('0, 1'b0);

      // Random traffic; alternating windows of frequent and rare ack to reach timeouts.
      rr = 8'($urandom);
      for (int i = 0; i < 1000; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            rr = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom) & 8'($urandom);
         end
         if ((i % 200) < 100) aa = ($urandom_range(0, 3) == 0);
         else                 aa = ($urandom_range(0, 40) == 0);
         if (i == 500) begin
            rst = 1'b1;
            #1;
            check("rand_rst_gnt", 32'(gnt), 32'd0);
            model_reset();
            #1;
            rst = 1'b0;
         end
         cycle(rr, aa);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/round_robin_arbiter.md
ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 8, the number of requesters.
REQ-002 The block SHALL have parameter IDXW, default 3, the width of the binary grant index (log2 N).
REQ-003 The block SHALL have parameter MAX_HOLD, default 16, the maximum number of cycles a grant is held without ack.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port req, input, N, one request bit per requester.
REQ-007 The block SHALL have port ack, input, 1, the current grant holder is done.
REQ-008 The block SHALL have port gnt, output, N, a registered one-hot grant, or all-zero when idle; it directly drives a one-hot-to-binary encoder.
REQ-009 The block SHALL have port gnt_valid, output, 1, registered, high while gnt is non-zero.
REQ-010 The block SHALL have port gnt_idx, output, IDXW, registered binary index of the set gnt bit; 0 when idle.
REQ-011 The block SHALL have port timeout, output, 1, a one-cycle registered pulse on forced release.

Function
REQ-012 The block SHALL implement a two-state FSM: IDLE (no grant) and GRANT (one grant held).
REQ-013 In IDLE with req non-zero at a rising edge, the block SHALL, at that edge, enter GRANT and set gnt to the first requester at or after pointer ptr, searching upward with wrap from N-1 to 0; latency is 1 cycle from req to gnt.
REQ-014 In IDLE with req all-zero, the block SHALL stay in IDLE with gnt=0, gnt_valid=0 and gnt_idx=0.
REQ-015 gnt SHALL never have more than one bit set; gnt_idx SHALL always equal the encoded position of the set bit.
REQ-016 In GRANT, gnt SHALL hold constant until release; a release is ack=1, req[gnt_idx]=0, or hold counter reaching MAX_HOLD.
REQ-017 On release, ptr SHALL become (gnt_idx+1) mod N, wrapping from N-1 to 0.
REQ-018 On release with other requesters active, the block SHALL grant the next requester from the new ptr at the same edge, giving a zero-bubble handover.
REQ-019 On release with no other requesters active, the block SHALL return to IDLE; the released requester, if it still requests, SHALL be granted again only via a later IDLE evaluation.
REQ-020 When ack and req-withdrawal occur in the same cycle, they SHALL be treated as one release.
REQ-021 The hold counter SHALL be IDXW-independent, width ceil(log2(MAX_HOLD+1)), cleared on every new grant, and SHALL increment each GRANT cycle without release.
REQ-022 On the cycle the count reaches MAX_HOLD-1 without ack, the block SHALL force a release at the next edge and set timeout=1 for exactly one cycle.
REQ-023 When ack arrives on the same cycle as the timeout condition, it SHALL take priority and timeout SHALL stay 0.
REQ-024 ack while in IDLE SHALL be ignored.

Reset
REQ-025 rst=1 SHALL asynchronously force state=IDLE, gnt=0, gnt_valid=0, gnt_idx=0, timeout=0, ptr=0 and hold counter=0, including mid-grant.
REQ-026 After rst deasserts, the first grant SHALL start its search from requester 0.

Structure
REQ-027 A shared package arb_pkg SHALL hold the default N, IDXW and MAX_HOLD constants and the FSM state typedef {IDLE, GRANT}.
REQ-028 The masked wrap-around priority search SHALL be a combinational sub-module rr_priority_pick with inputs req and ptr and outputs a one-hot pick and its index.
REQ-029 All outputs SHALL be driven from flops; none SHALL combinationally depend on req or ack.

Verification
REQ-030 Reset scenario: assert rst mid-grant with gnt=00000100 -> gnt=00000000 and gnt_valid=0 immediately, before the next clk edge; the next req=11111111 -> gnt=00000001.
REQ-031 Rotation scenario: req=11111111 held and ack pulsed every cycle -> gnt_idx sequence 0,1,2,...,7,0 with no idle cycle between grants.
REQ-032 Wrap scenario: ptr=7 (after granting 6) and req=10000001 -> gnt=10000000; after ack -> gnt=00000001.
REQ-033 Timeout scenario: req=00001000 held and ack held 0 -> gnt=00001000 for 16 cycles, then timeout=1 for one cycle and gnt=0 (IDLE), then regrant of idx 3.
REQ-034 Withdrawal scenario: grant at idx 2, then req[2] drops with req=00010000 -> next edge gnt=00010000 and timeout=0.
REQ-035 Encoder-chain scenario: the bench SHALL feed gnt into one_hot_encoder, check bin_out==gnt_idx every cycle for 1000 random req/ack cycles, and check that gnt is always one-hot or zero.
